negedge_capture_mon: RTL and testbench
======================================

NEGEDGE_CAPTURE_MON -- requirements
Module: negedge_capture_mon

Interface
REQ-001 SHALL have parameter DW, default 8, width of monitored register value.
REQ-002 SHALL have parameter DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mon_trig  input  1  monitored strobe, already synchronous to clk; falling edge marks a capture event.
REQ-006 SHALL have port mon_rst  input  1  monitored register reset, active-high; events are ignored while it is 1.
REQ-007 SHALL have port mon_data  input  DW  monitored register output.
REQ-008 SHALL have port exp_data  input  DW  value the monitored register must load on the event.
REQ-009 SHALL have port out_valid  output  1  FIFO head valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head.
REQ-011 SHALL have port out_payload  output  DW+17  {mismatch, timestamp[15:0], data[DW-1:0]} of head.
REQ-012 SHALL have port err_cnt  output  8  saturating mismatch count.
REQ-013 SHALL have port drop_cnt  output  8  saturating dropped-event count.
REQ-014 SHALL have port err_flag  output  1  sticky: any mismatch since reset.

Function
REQ-015 SHALL keep a free-running 16-bit timestamp, +1 per cycle, wrapping 0xFFFF->0x0000.
REQ-016 SHALL register mon_trig into trig_q each cycle; fall = trig_q & ~mon_trig.
REQ-017 SHALL, in cycle t where fall=1 and mon_rst=0, latch exp_q<=exp_data, ts_q<=timestamp, set pend<=1.
REQ-018 SHALL ignore fall when mon_rst=1: no pend, no count.
REQ-019 SHALL, in cycle t+1 with pend=1, compute mismatch = (mon_data != exp_q) and push {mismatch, ts_q, mon_data}; one event per pend, fixed check latency of 1 cycle after edge.
REQ-020 SHALL clear pend after the check unless a new qualifying fall occurs in the same cycle, in which case pend stays 1 with the new exp_q/ts_q (back-to-back events each checked once).
REQ-021 SHALL, when mon_rst rises while pend=1, still perform the check against mon_data that cycle.
REQ-022 SHALL increment err_cnt on each mismatch, saturating at 0xFF, and set err_flag; mismatches are counted even if the push is dropped.
REQ-023 SHALL implement FIFO: out_valid = not empty; pop when out_valid & out_ready; out_payload stable while out_valid & ~out_ready.
REQ-024 SHALL accept a push when not full, or when full with a pop in the same cycle; otherwise drop the entry and increment drop_cnt, saturating at 0xFF.
REQ-025 SHALL return first-in order; read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-026 SHALL make out_payload don't-care when out_valid=0; out_payload need not be zeroed.

Reset
REQ-027 SHALL, on clk edge with rst_n=0: timestamp=0, trig_q=0, pend=0, exp_q=0, ts_q=0, FIFO empty (out_valid=0), err_cnt=0, drop_cnt=0, err_flag=0.
REQ-028 SHALL discard a pending check and all FIFO contents on reset mid-operation; the first event after release needs a mon_trig 1->0 observed after reset (trig_q starts 0, so a line low at release produces no event).

Verification
REQ-029 SHALL cover: reset release, mon_trig 1->0 at timestamp 0x0010 with mon_rst=0, exp_data=0x5A, mon_data=0x5A next cycle, out_ready=1 -> one entry {0, 0x0010, 0x5A}, err_cnt=0.
REQ-030 SHALL cover: same edge but mon_data stays 0x00 (reset value) -> entry {1, ts, 0x00}, err_cnt=1, err_flag=1.
REQ-031 SHALL cover: mon_rst=1 during fall -> no entry, counters unchanged.
REQ-032 SHALL cover: out_ready=0, 10 falls with DEPTH=8 -> 8 entries held, drop_cnt=2; then drain gives entries in order with increasing timestamps.
REQ-033 SHALL cover: falls in consecutive-edge spacing (toggle every cycle) -> each event checked once; full FIFO with simultaneous pop and push -> no drop.
REQ-034 SHALL cover: rst_n=0 with pend=1 and 3 FIFO entries -> next cycle out_valid=0, no entry produced, counters 0; timestamp wraps 0xFFFF->0x0000 correctly in an entry.

Source files
------------

// File: rtl/negedge_capture_mon.sv
// Watches a register's load strobe: on each qualified falling edge, checks the register
// one cycle later against the expected value and queues {mismatch, timestamp, data}.
module negedge_capture_mon #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mon_trig,
  input  logic          mon_rst,
  input  logic [DW-1:0] mon_data,
  input  logic [DW-1:0] exp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+16:0] out_payload,
  output logic [7:0]    err_cnt,
  output logic [7:0]    drop_cnt,
  output logic          err_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + 17;

  logic [15:0]   tstamp_q, tstamp_d;
  logic          trig_q, trig_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [15:0]   ts_q, ts_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic          err_flag_q, err_flag_d;
  logic [PW-1:0] mem_q [DEPTH];

  logic fall, qual, mismatch, push, pop, full, accept, drop;

  always_comb begin
    fall     = trig_q & ~mon_trig;
    qual     = fall & ~mon_rst;
    // the check runs whenever an event is pending, even if mon_rst has just risen
    mismatch = pend_q & (mon_data != exp_q);
    push     = pend_q;
    pop      = out_valid & out_ready;
    full     = (cnt_q == (AW+1)'(DEPTH));
    accept   = push & (~full | pop);
    drop     = push & ~accept;

    tstamp_d   = tstamp_q + 16'd1;
    trig_d     = mon_trig;
    pend_d     = 1'b0;
    exp_d      = exp_q;
    ts_d       = ts_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_flag_d = err_flag_q;

    if (qual) begin
      pend_d = 1'b1;
      exp_d  = exp_data;
      ts_d   = tstamp_q;
    end
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tstamp_q   <= '0;
      trig_q     <= 1'b0;
      pend_q     <= 1'b0;
      exp_q      <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      tstamp_q   <= tstamp_d;
      trig_q     <= trig_d;
      pend_q     <= pend_d;
      exp_q      <= exp_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  // storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (rst_n && accept) mem_q[wr_ptr_q] <= {mismatch, ts_q, mon_data};
  end

  assign out_valid   = (cnt_q != '0);
  assign out_payload = mem_q[rd_ptr_q];
  assign err_cnt     = err_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_flag    = err_flag_q;
endmodule

// File: tb/tb_negedge_capture_mon.sv
// Randomized + directed bench for negedge_capture_mon against a queue-based event model.
module tb_negedge_capture_mon;
  localparam int DW = 8, DEPTH = 8, PW = DW + 17;

  logic clk = 1'b0, rst_n = 1'b0, mon_trig = 1'b0, mon_rst = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] mon_data = '0, exp_data = '0;
  logic out_valid, err_flag;
  logic [PW-1:0] out_payload;
  logic [7:0] err_cnt, drop_cnt;

  negedge_capture_mon #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mon_trig(mon_trig), .mon_rst(mon_rst),
    .mon_data(mon_data), .exp_data(exp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_payload(out_payload), .err_cnt(err_cnt),
    .drop_cnt(drop_cnt), .err_flag(err_flag));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // model: an event queue plus the one event awaiting its check
  logic [PW-1:0] m_q[$];
  int m_err = 0, m_drop = 0;
  bit m_flag = 0, m_known = 0, m_ptrig = 0, m_pend = 0;
  logic [15:0] m_ts = '0, m_pts = '0;
  logic [DW-1:0] m_pexp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit mm;
    if (!rst_n) begin
      m_q.delete(); m_err = 0; m_drop = 0; m_flag = 0; m_ts = '0;
      m_ptrig = 0; m_pend = 0; m_known = 1;
      return;
    end
    if (!m_known) return;
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (m_pend) begin
      mm = (mon_data != m_pexp);
      if (mm) begin
        if (m_err < 255) m_err++;
        m_flag = 1;
      end
      if (m_q.size() < DEPTH) m_q.push_back({mm, m_pts, mon_data});
      else if (m_drop < 255) m_drop++;
    end
    m_pend = m_ptrig && !mon_trig && !mon_rst;
    if (m_pend) begin
      m_pexp = exp_data;
      m_pts  = m_ts;
    end
    m_ptrig = mon_trig;
    m_ts    = m_ts + 16'd1;
  endtask

  // one cycle: compare at the falling edge, advance model, land just after the rising edge
  task automatic tick();
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("payload", 32'(out_payload), 32'(m_q[0]));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("err_flag", 32'(err_flag), 32'(m_flag));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mon_trig = 1'b0; mon_rst = 1'b0;
    mon_data = '0; exp_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic fall_pair();
    mon_trig = 1'b1; tick();
    mon_trig = 1'b0; exp_data = DW'($urandom); mon_data = DW'($urandom); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, n;
    // reset state and a matching event at timestamp 0x0010
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    out_ready = 1'b1; mon_trig = 1'b1;
    repeat (16) tick();
    mon_trig = 1'b0; exp_data = 8'h5A; tick();
    mon_data = 8'h5A; tick();
    chk("match_valid", 32'(out_valid), 32'd1);
    chk("match_payload", 32'(out_payload), {7'b0, 1'b0, 16'h0010, 8'h5A});
    chk("match_err", 32'(err_cnt), 32'd0);

    // register never loads: mismatch against its reset value
    do_reset();
    out_ready = 1'b1; mon_trig = 1'b1;
    repeat (16) tick();
    mon_trig = 1'b0; exp_data = 8'h5A; tick();
    tick();
    chk("mm_payload", 32'(out_payload), {7'b0, 1'b1, 16'h0010, 8'h00});
    chk("mm_err", 32'(err_cnt), 32'd1);
    chk("mm_flag", 32'(err_flag), 32'd1);
    tick();

    // fall while the monitored register is held in reset
    mon_trig = 1'b1; tick();
    mon_trig = 1'b0; mon_rst = 1'b1; exp_data = 8'h33; tick();
    mon_rst = 1'b0; tick(); tick();
    chk("ign_valid", 32'(out_valid), 32'd0);
    chk("ign_err", 32'(err_cnt), 32'd1);
    chk("ign_drop", 32'(drop_cnt), 32'd0);

    // overflow: 10 events into 8 entries, then drain in order
    do_reset();
    repeat (10) fall_pair();
    mon_trig = 1'b0; tick(); tick();
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    out_ready = 1'b1; prev = -1; n = 0;
    for (int k = 0; k < 20 && out_valid; k++) begin
      chk("drain_order", 32'(int'(out_payload[DW+15:DW]) > prev), 32'd1);
      prev = int'(out_payload[DW+15:DW]);
      n++;
      tick();
    end
    chk("drain_count", 32'(n), 32'd8);

    // strobe toggling every cycle
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      mon_trig = ~mon_trig; exp_data = DW'($urandom_range(0, 3));
      mon_data = DW'($urandom_range(0, 3)); tick();
    end

    // full FIFO with pop and push on the same edge
    do_reset();
    repeat (8) fall_pair();
    mon_trig = 1'b1; tick();
    chk("full_valid", 32'(out_valid), 32'd1);
    mon_trig = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    chk("full_popush_drop", 32'(drop_cnt), 32'd0);

    // reset with a pending check and 3 queued entries
    do_reset();
    repeat (3) fall_pair();
    mon_trig = 1'b1; tick();
    mon_trig = 1'b0; tick();
    rst_n = 1'b0; mon_trig = 1'b1; tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_err", 32'(err_cnt), 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1; mon_trig = 1'b0; tick(); tick(); tick();
    chk("postrst_noevt", 32'(out_valid), 32'd0);

    // timestamp wrap inside captured entries
    do_reset();
    mon_trig = 1'b1;
    repeat (65535) tick();
    mon_trig = 1'b0; tick();
    mon_trig = 1'b1; tick();
    mon_trig = 1'b0; tick();
    tick();
    chk("wrap_ts_ffff", 32'(out_payload[DW+15:DW]), 32'h0000_FFFF);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("wrap_ts_0001", 32'(out_payload[DW+15:DW]), 32'h0000_0001);

    // random traffic with rare resets
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 999) != 0);
      mon_trig  = 1'($urandom);
      mon_rst   = ($urandom_range(0, 9) == 0);
      exp_data  = DW'($urandom_range(0, 3));
      mon_data  = DW'($urandom_range(0, 3));
      out_ready = (k < 1500) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      tick();
    end
    // long stall so both counters saturate
    rst_n = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      mon_trig = 1'($urandom); mon_rst = 1'b0;
      exp_data = DW'($urandom_range(0, 3)); mon_data = DW'($urandom_range(0, 3));
      tick();
    end
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_err", 32'(err_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
